// File: rtl/mod_result_pkg.sv
// mod_result_pkg: shared types and constants for the modulo result stage.
package mod_result_pkg;

  localparam int MR_DEPTH     = 4;
  localparam int MR_RESULT_W  = 32;
  localparam int MR_OPERAND_W = 16;

  typedef enum logic {
    RUN   = 1'b0,
    ERROR = 1'b1
  } state_e;

  typedef struct packed {
    logic                   div_zero;
    logic [MR_RESULT_W-1:0] result;
  } entry_t;

endpackage

// File: rtl/mod_result_fifo.sv
// mod_result_fifo: synchronous FIFO of result entries with occupancy count.
// Full/empty are derived from the count; pointers wrap modulo DEPTH.
module mod_result_fifo
  import mod_result_pkg::*;
#(
  parameter int DEPTH = MR_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wr_data,
  output entry_t                 rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];
  logic             do_push, do_pop;

  // Qualify requests so a misbehaving caller cannot overrun or underrun.
  always_comb begin
    do_push  = push && (count_q != FULL_CNT);
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; stale contents are harmless because the head is gated by count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/mod_result_stage.sv
// mod_result_stage: buffered output stage behind the modulo unit.
// Tracks a sticky divide-by-zero error and the last good 16-bit operand.
// Optional: define MOD_RESULT_ERRCNT_EN to add a saturating err_count output.
//
//   state | meaning
//   RUN   | accepting results while FIFO has room
//   ERROR | divide-by-zero seen; pushes blocked until err_clear
module mod_result_stage
  import mod_result_pkg::*;
#(
  parameter int DEPTH = MR_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MR_RESULT_W-1:0]  in_result,
  input  logic                    in_div_zero,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MR_RESULT_W-1:0]  out_result,
  output logic                    out_div_zero,
  output logic [MR_OPERAND_W-1:0] feedback_operand,
  output logic                    err_sticky,
  input  logic                    err_clear,
  output logic [$clog2(DEPTH):0]  count
`ifdef MOD_RESULT_ERRCNT_EN
  ,
  output logic [15:0]             err_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  state_e                  state_q, state_d;
  logic [MR_OPERAND_W-1:0] fb_q, fb_d;
  logic [CNT_W-1:0]        fifo_count;
  entry_t                  wr_entry, head;
  logic                    push, pop;

  // Handshakes depend only on registered state, count and reset.
  always_comb begin
    in_ready  = (state_q == RUN) && (fifo_count != FULL_CNT) && !rst;
    out_valid = (fifo_count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Build the stored entry; a divide-by-zero result is forced to zero.
  always_comb begin
    wr_entry.div_zero = in_div_zero;
    wr_entry.result   = in_div_zero ? '0 : in_result;
  end

  // Next state, feedback operand update.
  always_comb begin
    state_d = state_q;
    fb_d    = fb_q;
    case (state_q)
      RUN: begin
        if (push && in_div_zero) state_d = ERROR;
      end
      ERROR: begin
        if (err_clear) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (push && !in_div_zero) fb_d = in_result[MR_OPERAND_W-1:0];
  end

  // State and feedback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      fb_q    <= fb_d;
    end
  end

  mod_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (fifo_count)
  );

  assign out_result       = out_valid ? head.result : '0;
  assign out_div_zero     = out_valid ? head.div_zero : 1'b0;
  assign feedback_operand = fb_q;
  assign err_sticky       = (state_q == ERROR);
  assign count            = fifo_count;

`ifdef MOD_RESULT_ERRCNT_EN
  logic [15:0] errcnt_q, errcnt_d;

  // Saturating count of divide-by-zero pushes; only reset clears it.
  always_comb begin
    errcnt_d = errcnt_q;
    if (push && in_div_zero && (errcnt_q != 16'hFFFF)) errcnt_d = errcnt_q + 16'd1;
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) errcnt_q <= '0;
    else     errcnt_q <= errcnt_d;
  end

  assign err_count = errcnt_q;
`endif

endmodule
